// File: rtl/ssd_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns (active-high,
// {g,f,e,d,c,b,a}), scan slot encoding and slot helpers.
package ssd_scan_driver_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Slot index doubles as the shadow-array index (0 = leftmost digit).
    typedef enum logic [1:0] {
        SLOT_D1 = 2'd0,
        SLOT_D2 = 2'd1,
        SLOT_D3 = 2'd2,
        SLOT_D4 = 2'd3
    } slot_t;

    function automatic slot_t slot_succ(input slot_t s);
        case (s)
            SLOT_D1: slot_succ = SLOT_D2;
            SLOT_D2: slot_succ = SLOT_D3;
            SLOT_D3: slot_succ = SLOT_D4;
            default: slot_succ = SLOT_D1;
        endcase
    endfunction

    // Active-high anode for a slot: digit 1 sits on anode bit 3.
    function automatic logic [3:0] slot_anode(input slot_t s);
        case (s)
            SLOT_D1: slot_anode = 4'b1000;
            SLOT_D2: slot_anode = 4'b0100;
            SLOT_D3: slot_anode = 4'b0010;
            default: slot_anode = 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Counter-to-display bundle: digit values, DP requests and enable in; pin drives and frame strobe out.
interface ssd_scan_driver_if;

    logic       i_EN;
    logic [3:0] i_Digit_1_val;
    logic [3:0] i_Digit_2_val;
    logic [3:0] i_Digit_3_val;
    logic [3:0] i_Digit_4_val;
    logic [3:0] i_DP;
    logic [3:0] o_AN;
    logic [6:0] o_SEG;
    logic       o_DP;
    logic       o_FRAME;

    modport master (
        output i_EN, i_Digit_1_val, i_Digit_2_val, i_Digit_3_val, i_Digit_4_val, i_DP,
        input  o_AN, o_SEG, o_DP, o_FRAME
    );

    modport slave (
        input  i_EN, i_Digit_1_val, i_Digit_2_val, i_Digit_3_val, i_Digit_4_val, i_DP,
        output o_AN, o_SEG, o_DP, o_FRAME
    );

endinterface

// File: rtl/ssd_hex_decoder.sv
// Combinational hex digit to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module ssd_hex_decoder
    import ssd_scan_driver_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_val)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver with per-frame snapshot, anti-ghost blanking,
// leading-zero suppression and registered outputs.
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int c_REFRESH_DIV = 100000,
    parameter int c_GHOST       = 16,
    parameter int c_ACTIVE_LOW  = 1,
    parameter int c_BLANK_LZ    = 1
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    ssd_scan_driver_if.slave     io_ssd
);

    localparam int              c_PS_W      = (c_REFRESH_DIV > 1) ? $clog2(c_REFRESH_DIV) : 1;
    localparam logic [c_PS_W-1:0] c_PS_MAX  = c_PS_W'(c_REFRESH_DIV - 1);
    localparam logic [c_PS_W-1:0] c_GHOST_END = c_PS_W'(c_GHOST);
    localparam logic            c_INV       = (c_ACTIVE_LOW != 0);
    localparam logic            c_LZ        = (c_BLANK_LZ != 0);
    localparam logic [3:0]      c_AN_OFF    = c_INV ? 4'hF : 4'h0;
    localparam logic [6:0]      c_SEG_IDLE  = c_INV ? ~SEG_OFF : SEG_OFF;

    logic [c_PS_W-1:0] r_prescaler;
    slot_t             r_slot;
    logic              r_load_pend;
    logic [3:0]        r_shadow [4];
    logic [3:0]        r_shadow_dp;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic              r_frame;

    logic [c_PS_W-1:0] w_prescaler_next;
    slot_t             w_slot_next;
    logic              w_tick;
    logic              w_load;
    logic [3:0]        w_digit_in [4];
    logic [3:0]        w_zero;
    logic [3:0]        w_blank;
    logic [3:0]        w_sel_digit;
    logic [6:0]        w_sel_pattern;
    logic              w_sel_dp;
    logic [3:0]        w_an_ah;
    logic [6:0]        w_seg_ah;
    logic              w_dp_ah;
    logic [3:0]        w_an_next;
    logic [6:0]        w_seg_next;
    logic              w_dp_next;

    assign w_digit_in[0] = io_ssd.i_Digit_1_val;
    assign w_digit_in[1] = io_ssd.i_Digit_2_val;
    assign w_digit_in[2] = io_ssd.i_Digit_3_val;
    assign w_digit_in[3] = io_ssd.i_Digit_4_val;

    // Shadow slots are indexed by scan slot; DP bits are stored reversed so slot N reads bit N.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_shadow
            always_ff @(posedge i_CLK or posedge i_RST) begin
                if (i_RST) begin
                    r_shadow[gi]    <= 4'd0;
                    r_shadow_dp[gi] <= 1'b0;
                end else if (w_load) begin
                    r_shadow[gi]    <= w_digit_in[gi];
                    r_shadow_dp[gi] <= io_ssd.i_DP[3-gi];
                end
            end

            assign w_zero[gi] = (r_shadow[gi] == 4'd0);

            // A digit is blank only when it and every digit to its left are zero; the last never is.
            if (gi < 3) begin : g_lz
                assign w_blank[gi] = c_LZ & (&w_zero[gi:0]);
            end else begin : g_last
                assign w_blank[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_sel_digit = r_shadow[r_slot];

    ssd_hex_decoder u_hex_decoder (
        .i_val (w_sel_digit),
        .o_seg (w_sel_pattern)
    );

    always_comb begin
        w_tick           = (r_prescaler == c_PS_MAX);
        w_load           = r_load_pend | (w_tick & (r_slot == SLOT_D4));
        w_prescaler_next = w_tick ? '0 : r_prescaler + 1'b1;
        w_slot_next      = w_tick ? slot_succ(r_slot) : r_slot;
        w_sel_dp         = r_shadow_dp[r_slot];

        w_an_ah  = 4'h0;
        w_seg_ah = SEG_OFF;
        w_dp_ah  = 1'b0;
        if (io_ssd.i_EN && (r_prescaler >= c_GHOST_END)) begin
            w_dp_ah = w_sel_dp;
            if (w_blank[r_slot]) begin
                w_an_ah = w_sel_dp ? slot_anode(r_slot) : 4'h0;
            end else begin
                w_an_ah  = slot_anode(r_slot);
                w_seg_ah = w_sel_pattern;
            end
        end

        w_an_next  = c_INV ? ~w_an_ah  : w_an_ah;
        w_seg_next = c_INV ? ~w_seg_ah : w_seg_ah;
        w_dp_next  = c_INV ? ~w_dp_ah  : w_dp_ah;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_prescaler <= '0;
            r_slot      <= SLOT_D1;
            r_load_pend <= 1'b1;
            r_an        <= c_AN_OFF;
            r_seg       <= c_SEG_IDLE;
            r_dp        <= c_INV;
            r_frame     <= 1'b0;
        end else begin
            r_prescaler <= w_prescaler_next;
            r_slot      <= w_slot_next;
            r_load_pend <= 1'b0;
            r_an        <= w_an_next;
            r_seg       <= w_seg_next;
            r_dp        <= w_dp_next;
            r_frame     <= w_load;
        end
    end

    assign io_ssd.o_AN    = r_an;
    assign io_ssd.o_SEG   = r_seg;
    assign io_ssd.o_DP    = r_dp;
    assign io_ssd.o_FRAME = r_frame;

endmodule
